// File: rtl/tensor_pingpong_ram.sv
// Double-buffered tensor store: granule writes into one bank, wide reads from the other.
// Optional macro TENSOR_PINGPONG_OUTREG_EN adds a second read output register stage.
module tensor_pingpong_ram #(
  parameter int unsigned READ_WIDTH  = 128,
  parameter int unsigned WRITE_WIDTH = 8,
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned BPW = READ_WIDTH / WRITE_WIDTH,
  localparam int unsigned AW  = $clog2(DEPTH_WORDS * BPW),
  localparam int unsigned RW  = $clog2(DEPTH_WORDS),
  localparam int unsigned LW  = RW + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WRITE_WIDTH-1:0] wr_data,
  input  logic                   wr_commit,
  output logic                   wr_ready,
  output logic [LW-1:0]          wr_words,
  input  logic                   rd_en,
  input  logic [RW-1:0]          rd_addr,
  input  logic                   rd_release,
  output logic                   rd_avail,
  output logic                   rd_valid,
  output logic [READ_WIDTH-1:0]  rd_data,
  output logic                   rd_pad
);

  localparam int unsigned LNW = (BPW > 1) ? $clog2(BPW) : 1;

  // Bank b occupies words [b*DEPTH_WORDS, (b+1)*DEPTH_WORDS).
  logic [READ_WIDTH-1:0] mem [2*DEPTH_WORDS];

  logic [1:0]    full_q;
  logic [LW-1:0] len_q [2];
  logic          wr_bank_q;
  logic          rd_bank_q;
  logic [LW-1:0] wr_words_q;

  logic          wr_acc;
  logic          commit_acc;
  logic          rd_acc;
  logic          release_acc;
  logic [RW-1:0] wr_word;
  logic [LNW-1:0] wr_lane;
  logic [LW-1:0] word_inc;
  logic [LW-1:0] wr_hw;
  logic          rd_hit;

  assign wr_ready    = ~full_q[wr_bank_q];
  assign rd_avail    = full_q[rd_bank_q];
  assign wr_acc      = wr_en & wr_ready;
  assign commit_acc  = wr_commit & wr_ready;
  assign rd_acc      = rd_en & rd_avail;
  assign release_acc = rd_release & rd_avail;
  assign wr_words    = wr_words_q;

  assign wr_word  = RW'(wr_addr / AW'(BPW));
  assign wr_lane  = LNW'(wr_addr % AW'(BPW));
  assign word_inc = {1'b0, wr_word} + LW'(1);
  // High-water including this cycle's write, so a same-cycle commit captures it.
  assign wr_hw    = (wr_acc && (word_inc > wr_words_q)) ? word_inc : wr_words_q;
  assign rd_hit   = {1'b0, rd_addr} < len_q[rd_bank_q];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[{wr_bank_q, wr_word}][wr_lane*WRITE_WIDTH +: WRITE_WIDTH] <= wr_data;
    end
  end

  // Commit only touches an EMPTY bank and release only a FULL one, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= '0;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_words_q <= '0;
    end else begin
      wr_words_q <= wr_hw;
      if (commit_acc) begin
        full_q[wr_bank_q] <= 1'b1;
        len_q[wr_bank_q]  <= wr_hw;
        wr_bank_q         <= ~wr_bank_q;
        wr_words_q        <= '0;
      end
      if (release_acc) begin
        full_q[rd_bank_q] <= 1'b0;
        rd_bank_q         <= ~rd_bank_q;
      end
    end
  end

  logic                  rd_valid_q;
  logic [READ_WIDTH-1:0] rd_data_q;
  logic                  rd_pad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_pad_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= rd_hit ? mem[{rd_bank_q, rd_addr}] : '0;
        rd_pad_q  <= ~rd_hit;
      end
    end
  end

`ifdef TENSOR_PINGPONG_OUTREG_EN
  logic                  rd_valid_q2;
  logic [READ_WIDTH-1:0] rd_data_q2;
  logic                  rd_pad_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q2 <= 1'b0;
      rd_data_q2  <= '0;
      rd_pad_q2   <= 1'b0;
    end else begin
      rd_valid_q2 <= rd_valid_q;
      if (rd_valid_q) begin
        rd_data_q2 <= rd_data_q;
        rd_pad_q2  <= rd_pad_q;
      end
    end
  end

  assign rd_valid = rd_valid_q2;
  assign rd_data  = rd_data_q2;
  assign rd_pad   = rd_pad_q2;
`else
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_pad   = rd_pad_q;
`endif

endmodule

// File: tb/tb_tensor_pingpong_ram.sv
// Scoreboard bench for tensor_pingpong_ram: byte-level reference model, queued read expectations.
module tb_tensor_pingpong_ram;

  localparam int BPW   = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 14;
  localparam int RW    = 10;
  localparam int LW    = 11;
`ifdef TENSOR_PINGPONG_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [7:0]     wr_data = '0;
  logic           wr_commit = 1'b0;
  logic           wr_ready;
  logic [LW-1:0]  wr_words;
  logic           rd_en = 1'b0;
  logic [RW-1:0]  rd_addr = '0;
  logic           rd_release = 1'b0;
  logic           rd_avail;
  logic           rd_valid;
  logic [127:0]   rd_data;
  logic           rd_pad;

  tensor_pingpong_ram dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .wr_ready   (wr_ready),
    .wr_words   (wr_words),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_release (rd_release),
    .rd_avail   (rd_avail),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_pad     (rd_pad)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte array per bank plus ownership flags and committed lengths.
  logic [7:0] m_mem [2][BPW*DEPTH];
  bit         m_full [2];
  int         m_len [2];
  int         m_wb, m_rb, m_hw;

  typedef struct {
    logic [127:0] data;
    logic         pad;
    int           due;
  } exp_t;
  exp_t q[$];

  function automatic logic [127:0] model_word(input int b, input int w);
    logic [127:0] r;
    for (int k = 0; k < BPW; k++) r[k*8 +: 8] = m_mem[b][w*BPW + k];
    return r;
  endfunction

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_len[0] = 0;  m_len[1] = 0;
    m_wb = 0; m_rb = 0; m_hw = 0;
  endtask

  // One clock: predict effects from the model, apply inputs, then check handshake outputs.
  task automatic step(input bit we, input int wa, input int wd, input bit wc,
                      input bit re, input int ra, input bit rr);
    bit   wr_ok, rd_ok;
    exp_t e;
    wr_ok = !m_full[m_wb];
    rd_ok = m_full[m_rb];
    wr_en = we; wr_addr = AW'(wa); wr_data = 8'(wd); wr_commit = wc;
    rd_en = re; rd_addr = RW'(ra); rd_release = rr;
    if (re && rd_ok) begin
      e.pad  = (ra >= m_len[m_rb]);
      e.data = e.pad ? 128'h0 : model_word(m_rb, ra);
      e.due  = cyc + LAT;
      q.push_back(e);
    end
    if (we && wr_ok) begin
      m_mem[m_wb][wa] = 8'(wd);
      if (wa / BPW + 1 > m_hw) m_hw = wa / BPW + 1;
    end
    if (wc && wr_ok) begin
      m_full[m_wb] = 1; m_len[m_wb] = m_hw; m_wb ^= 1; m_hw = 0;
    end
    if (rr && rd_ok) begin
      m_full[m_rb] = 0; m_rb ^= 1;
    end
    @(posedge clk);
    #1;
    wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0;
    chk("wr_ready", wr_ready, !m_full[m_wb]);
    chk("rd_avail", rd_avail, m_full[m_rb]);
    chk("wr_words", wr_words, m_hw);
  endtask

  task automatic wr(input int a, input int d); step(1, a, d, 0, 0, 0, 0); endtask
  task automatic commit();                     step(0, 0, 0, 1, 0, 0, 0); endtask
  task automatic rd(input int a);              step(0, 0, 0, 0, 1, a, 0); endtask
  task automatic rel();                        step(0, 0, 0, 0, 0, 0, 1); endtask

  // Monitor: pops one expectation per rd_valid and flags missing or spurious results.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rd_valid) begin
        if (q.size() == 0) begin
          chk("rd_valid_spurious", rd_valid, 1'b0);
        end else begin
          e = q.pop_front();
          chk("rd_data", rd_data, e.data);
          chk("rd_pad", rd_pad, e.pad);
          chk("rd_latency_cycle", cyc, e.due);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("rd_valid_missing", rd_valid, 1'b1);
      end
    end
  end

  task automatic first_scenario(input string tag);
    int n;
    for (int i = 0; i < 16; i++) wr(i, i);
    chk({tag, "_wr_words_pre"}, wr_words, 1);
    commit();
    chk({tag, "_wr_words_post"}, wr_words, 0);
    rd(0);
    n = 1;
    while (!rd_valid && n < 6) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_data"}, rd_data, 128'h0f0e0d0c0b0a09080706050403020100);
    chk({tag, "_pad"}, rd_pad, 1'b0);
    rel();
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < BPW*DEPTH; i++) m_mem[b][i] = 8'h00;
    model_reset();

    #2;
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_rd_avail", rd_avail, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 128'h0);
    chk("rst_rd_pad", rd_pad, 1'b0);
    chk("rst_wr_words", wr_words, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    first_scenario("basic");

    // Byte merge into bank 1, word 1.
    wr(17, 8'hAA); wr(31, 8'hBB); commit(); rd(1); rel();

    // Padding: len = 2, then an empty commit.
    wr(3, 8'h33); wr(20, 8'h44); wr(16, 8'h55); commit();
    rd(1); rd(2); rd(1023); rd(0); rel();
    commit(); rd(0); rd(5); rel();

    // Ping-pong: both banks full, dropped writes and commit, then release.
    for (int i = 32; i < 48; i++) wr(i, 8'h80 + i);
    commit();
    wr(0, 8'h11); wr(17, 8'h22); commit();
    wr(32, 8'hEE); wr(40, 8'hEE); wr(200, 8'hEE); commit();
    rd(2); rel(); rd(0); rd(1);
    wr(5, 8'h66); wr(36, 8'h77);
    step(0, 0, 0, 1, 0, 0, 1);
    rd(0); rd(2); rel();

    // Read while nothing available, then a read in the same cycle as its bank's release.
    rd(0);
    wr(48, 8'h99); commit();
    step(0, 0, 0, 0, 1, 3, 1);
    rd(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int wa, ra;
      wa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, BPW*DEPTH-1))
                                       : int'($urandom_range(0, 95));
      ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH-1))
                                       : int'($urandom_range(0, 7));
      step($urandom_range(0, 1) == 1, wa, int'($urandom_range(0, 255)),
           $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1, ra,
           $urandom_range(0, 7) == 0);
    end
    while (m_full[m_rb]) rel();

    // Reset in the middle of a read burst.
    wr(1, 8'h5A); commit(); rd(0); rd(0); rd(0);
    #2 rst_n = 1'b0;
    q.delete();
    model_reset();
    #1;
    chk("midrst_rd_valid", rd_valid, 1'b0);
    chk("midrst_rd_data", rd_data, 128'h0);
    chk("midrst_rd_pad", rd_pad, 1'b0);
    chk("midrst_wr_ready", wr_ready, 1'b1);
    chk("midrst_rd_avail", rd_avail, 1'b0);
    chk("midrst_wr_words", wr_words, 0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    first_scenario("after_rst");

    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
